// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: Set-2 byte constants,
// sequencer state encoding and the packed key-event payload.
package ps2_kbd_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EVT_W  = 10;

  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_PAUSE = 8'hE1;
  localparam logic [BYTE_W-1:0] PS2_BAT   = 8'hAA;
  localparam logic [BYTE_W-1:0] PS2_ACK   = 8'hFA;
  localparam logic [BYTE_W-1:0] PS2_ECHO  = 8'hEE;
  localparam logic [BYTE_W-1:0] PS2_ERR0  = 8'h00;
  localparam logic [BYTE_W-1:0] PS2_ERR1  = 8'hFF;

  // Pause is E1 followed by seven more bytes.
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

  typedef struct packed {
    logic              ext;
    logic              brk;
    logic [BYTE_W-1:0] code;
  } evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with simultaneous push/pop.
//   push/wdata : write request (accepted when not full, or when popping)
//   pop        : read request (ignored when empty)
//   rdata      : head entry
//   count/full/empty : occupancy status
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: turns Set-2 scancode bytes into key events
// (code, extended, break), queues them and throttles the keyboard.
//   rx_data/rx_rdy         : byte stream from the device-to-host receiver
//   evt_*/evt_valid/ready  : head of event queue, valid/ready handshake
//   clk_inhibit            : hold PS/2 clock low while queue nearly full
//   bat_ok/kbd_err         : one-cycle status pulses (AA / 00,FF)
//   ovf/ovf_clr            : sticky drop flag and its clear
module ps2_kbd_ctrl
  import ps2_kbd_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PREFIX_TO  = 24000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic [BYTE_W-1:0] evt_code,
  output logic              evt_ext,
  output logic              evt_brk,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              clk_inhibit,
  output logic              bat_ok,
  output logic              kbd_err,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned TW = $clog2(PREFIX_TO);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic [2:0]    skip_cnt, skip_cnt_nx;
  logic          bat_nx, err_nx;
  logic          push_c;
  evt_t          push_evt_c;
  evt_t          head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_c;

  assign pop_c     = evt_valid & evt_ready;
  assign evt_valid = ~fifo_empty;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;
  assign evt_code  = head.code;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (push_evt_c),
    .pop   (pop_c),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      skip_cnt    <= '0;
      bat_ok      <= 1'b0;
      kbd_err     <= 1'b0;
      ovf         <= 1'b0;
      clk_inhibit <= 1'b0;
    end else begin
      state    <= state_nx;
      to_cnt   <= to_cnt_nx;
      skip_cnt <= skip_cnt_nx;
      bat_ok   <= bat_nx;
      kbd_err  <= err_nx;
      // Set wins over clear.
      if (push_c && fifo_full && !pop_c) ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
      // Hysteresis leaves room for one byte already on the wire.
      if (fifo_count >= CW'(FIFO_DEPTH - 1)) clk_inhibit <= 1'b1;
      else if (fifo_count <= CW'(1))         clk_inhibit <= 1'b0;
    end
  end

  // Next-state, push decode and prefix timeout.
  always_comb begin
    state_nx    = state;
    skip_cnt_nx = skip_cnt;
    to_cnt_nx   = '0;
    bat_nx      = 1'b0;
    err_nx      = 1'b0;
    push_c      = 1'b0;
    push_evt_c  = '{ext: 1'b0, brk: 1'b0, code: rx_data};

    if (state != ST_IDLE && !rx_rdy) begin
      if (to_cnt == TW'(PREFIX_TO - 1)) state_nx  = ST_IDLE;
      else                               to_cnt_nx = to_cnt + TW'(1);
    end

    if (rx_rdy) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) state_nx = ST_EXT;
          else if (rx_data == PS2_BRK) state_nx = ST_BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_nx    = ST_SKIP;
            skip_cnt_nx = SKIP_LEN;
          end
          else if (rx_data == PS2_BAT) bat_nx = 1'b1;
          else if (rx_data == PS2_ERR0 || rx_data == PS2_ERR1) err_nx = 1'b1;
          else if (rx_data == PS2_ACK || rx_data == PS2_ECHO) push_c = 1'b0;
          else push_c = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) state_nx = ST_EXT_BRK;
          else if (rx_data != PS2_EXT) begin
            push_c         = 1'b1;
            push_evt_c.ext = 1'b1;
            state_nx       = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_c         = 1'b1;
          push_evt_c.brk = 1'b1;
          state_nx       = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_c         = 1'b1;
          push_evt_c.ext = 1'b1;
          push_evt_c.brk = 1'b1;
          state_nx       = ST_IDLE;
        end
        ST_SKIP: begin
          skip_cnt_nx = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            push_c     = 1'b1;
            push_evt_c = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE};
            state_nx   = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl.
module tb_ps2_kbd_ctrl;

  localparam int unsigned PREFIX_TO = 24000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_brk, evt_valid;
  logic       evt_ready = 1'b0;
  logic       clk_inhibit, bat_ok, kbd_err, ovf;
  logic       ovf_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(4), .PREFIX_TO(PREFIX_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_brk     (evt_brk),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .clk_inhibit (clk_inhibit),
    .bat_ok      (bat_ok),
    .kbd_err     (kbd_err),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One-cycle rx_rdy pulse; returns at the following falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  // Head must be valid with {ext,brk,code}; then popped.
  task automatic expect_pop(input string tag, input logic [9:0] exp);
    check({tag, "_valid"}, 16'(evt_valid), 16'd1);
    check({tag, "_evt"}, 16'({evt_ext, evt_brk, evt_code}), 16'(exp));
    pop();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(evt_valid), 16'd0);
    check("rst_evt", 16'({evt_ext, evt_brk, evt_code}), 16'd0);
    check("rst_misc", 16'({clk_inhibit, bat_ok, kbd_err, ovf}), 16'd0);
    rst = 1'b1;

    // Basic make/break/extended sequences.
    send(8'h1C);
    expect_pop("make", {2'b00, 8'h1C});
    check("make_empty", 16'(evt_valid), 16'd0);
    send(8'hF0); check("brk_mid", 16'(evt_valid), 16'd0);
    send(8'h1C);
    expect_pop("brk", {2'b01, 8'h1C});
    send(8'hE0); send(8'h75);
    expect_pop("ext", {2'b10, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_pop("extbrk", {2'b11, 8'h75});
    send(8'hE0); send(8'hAA);
    expect_pop("ext_status", {2'b10, 8'hAA});
    send(8'hFA); send(8'hEE);
    check("ack_echo", 16'(evt_valid), 16'd0);

    // Pause: exactly one event after the eighth byte.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    check("pause_mid", 16'(evt_valid), 16'd0);
    send(8'h77);
    expect_pop("pause", {2'b10, 8'hE1});
    check("pause_empty", 16'(evt_valid), 16'd0);

    // Prefix timeout drops the E0.
    send(8'hE0);
    repeat (PREFIX_TO + 2) @(negedge clk);
    send(8'h1C);
    expect_pop("timeout", {2'b00, 8'h1C});

    // Fill, inhibit, overflow, drain.
    send(8'h15); send(8'h16);
    repeat (2) @(negedge clk);
    check("inh_two", 16'(clk_inhibit), 16'd0);
    send(8'h17);
    @(negedge clk);
    check("inh_three", 16'(clk_inhibit), 16'd1);
    send(8'h18);
    check("ovf_before", 16'(ovf), 16'd0);
    send(8'h19);
    check("ovf_set", 16'(ovf), 16'd1);
    expect_pop("drain0", {2'b00, 8'h15});
    expect_pop("drain1", {2'b00, 8'h16});
    check("inh_cnt2", 16'(clk_inhibit), 16'd1);
    expect_pop("drain2", {2'b00, 8'h17});
    @(negedge clk);
    check("inh_cnt1", 16'(clk_inhibit), 16'd0);
    check("ovf_sticky", 16'(ovf), 16'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_clr", 16'(ovf), 16'd0);
    expect_pop("drain3", {2'b00, 8'h18});
    check("drain_empty", 16'(evt_valid), 16'd0);

    // Full FIFO with simultaneous push and pop.
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    @(negedge clk);
    rx_data = 8'h25; rx_rdy = 1'b1; evt_ready = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0; evt_ready = 1'b0;
    check("pp_ovf", 16'(ovf), 16'd0);
    expect_pop("pp0", {2'b00, 8'h22});
    expect_pop("pp1", {2'b00, 8'h23});
    expect_pop("pp2", {2'b00, 8'h24});
    expect_pop("pp3", {2'b00, 8'h25});
    check("pp_empty", 16'(evt_valid), 16'd0);

    // Status bytes.
    send(8'hAA);
    check("bat_pulse", 16'({bat_ok, kbd_err}), 16'b10);
    @(negedge clk);
    check("bat_end", 16'({bat_ok, evt_valid}), 16'd0);
    send(8'hFF);
    check("err_pulse", 16'({bat_ok, kbd_err}), 16'b01);
    @(negedge clk);
    check("err_end", 16'({kbd_err, evt_valid}), 16'd0);
    send(8'h00);
    check("err0_pulse", 16'(kbd_err), 16'd1);

    // Reset mid-prefix.
    send(8'h33); send(8'hE0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_rst_valid", 16'(evt_valid), 16'd0);
    check("mid_rst_outs", 16'({evt_ext, evt_brk, evt_code, clk_inhibit, bat_ok, kbd_err, ovf}), 16'd0);
    @(negedge clk); rst = 1'b1;
    send(8'h1C);
    expect_pop("post_rst", {2'b00, 8'h1C});
    check("post_rst_empty", 16'(evt_valid), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
